hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the PC write enable consumed by the PC register, plus the IF/ID and ID/EX write enables, bubble and flush controls.
- Detects load-use hazards and ID-stage branch/jump redirects combinationally.
- Sequences multi-cycle EX operations (mult/div) with a registered countdown FSM that freezes the front end.

---
 rtl/hazard_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, ID-stage redirect flushes and
// a countdown FSM that freezes the front end during multi-cycle EX ops.
module hazard_ctrl #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned MC_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             ex_mc_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             ifid_flush,
    output logic             busy,
    output logic [3:0]       stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(MC_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_lu;

    // $zero is never a real dependency, so it cannot cause a load-use stall.
    assign w_lu = idex_mem_read && (idex_rt != '0) &&
                  ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        busy         = 1'b0;
        stall_cnt    = '0;

        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            ifid_flush   = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_mc_start) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        if (MC_LAT > 1) begin
                            w_state_nxt = MC_WAIT;
                            w_cnt_nxt   = LP_CNT_LOAD;
                        end
                    end else if (w_lu) begin
                        // Redirect is deliberately not flushed; it re-resolves next cycle.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_branch_taken || id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    busy         = 1'b1;
                    stall_cnt    = r_cnt;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule
